// File: rtl/mips_pkg.sv
// Shared definitions for the five-stage MIPS core: opcodes, bubble word,
// reset vector, fetch FSM encoding and the IF/ID latch payload.
package mips_pkg;

  localparam logic [5:0] OP_R   = 6'd0;
  localparam logic [5:0] OP_J   = 6'd2;
  localparam logic [5:0] OP_JAL = 6'd3;
  localparam logic [5:0] OP_BEQ = 6'd4;
  localparam logic [5:0] OP_LW  = 6'd35;
  localparam logic [5:0] OP_SW  = 6'd43;

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_MISS = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  // Instruction addresses are word aligned; low bits of a target are dropped.
  function automatic logic [31:0] pc_align(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline latch: flush inserts a bubble, hold freezes, load captures
// the fetched word. Flush has priority over hold, hold over load.
module if_id_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_hold,
  input  logic        i_flush,
  input  logic        i_load,
  input  logic [31:0] i_ir,
  input  logic [31:0] i_pc_plus4,
  output logic [31:0] o_ir,
  output logic [31:0] o_pc_plus4,
  output logic        o_valid
);

  if_id_t r_q;

  // IF/ID state update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '{ir: NOP, pc_plus4: 32'h0000_0000, valid: 1'b0};
    end else if (i_flush) begin
      r_q <= '{ir: NOP, pc_plus4: 32'h0000_0000, valid: 1'b0};
    end else if (i_hold) begin
      r_q <= r_q;
    end else if (i_load) begin
      r_q <= '{ir: i_ir, pc_plus4: i_pc_plus4, valid: 1'b1};
    end else begin
      r_q <= r_q;
    end
  end

  assign o_ir       = r_q.ir;
  assign o_pc_plus4 = r_q.pc_plus4;
  assign o_valid    = r_q.valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, I-cache read handshake, redirect handling
// (including redirects that arrive during a cache miss) and the IF/ID latch.
module fetch_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        oICACHE_ren,
  output logic [29:0] oICACHE_addr,
  input  logic [31:0] iICACHE_rdata,
  input  logic        iICACHE_stall,
  input  logic        iStall,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectPC,
  output logic [31:0] oIR,
  output logic [31:0] oPC_plus4,
  output logic        oValid
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic         r_ren;
  logic [29:0]  r_addr;
  logic         r_pend_v;
  logic [31:0]  r_pend_pc;

  logic [31:0] w_pc_plus4;
  logic        w_redir;
  logic [31:0] w_target;
  logic        w_active;
  logic        w_flush;
  logic        w_load;
  logic        w_hold;
  logic [31:0] w_pc_next;

  assign w_pc_plus4 = r_pc + 32'd4;

  // Effective redirect: a fresh pulse beats one parked during a miss
  always_comb begin
    w_redir  = 1'b0;
    w_target = r_pend_pc;
    if (iRedirect) begin
      w_redir  = 1'b1;
      w_target = iRedirectPC;
    end else if (r_pend_v) begin
      w_redir  = 1'b1;
      w_target = r_pend_pc;
    end else begin
      w_redir  = 1'b0;
      w_target = r_pend_pc;
    end
  end

  assign w_active = (r_state != S_BOOT) && !iICACHE_stall;
  assign w_flush  = w_active && w_redir;
  assign w_load   = w_active && !w_redir && !iStall;
  assign w_hold   = !w_flush && !w_load;

  // Next-PC selection for a cycle in which the cache returned data
  always_comb begin
    w_pc_next = r_pc;
    if (w_flush) begin
      w_pc_next = pc_align(w_target);
    end else if (w_load) begin
      w_pc_next = w_pc_plus4;
    end else begin
      w_pc_next = r_pc;
    end
  end

  // Fetch FSM, PC, registered cache request and pending redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_BOOT;
      r_pc      <= RESET_PC;
      r_ren     <= 1'b0;
      r_addr    <= 30'd0;
      r_pend_v  <= 1'b0;
      r_pend_pc <= 32'h0000_0000;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state <= S_RUN;
          r_ren   <= 1'b1;
          r_addr  <= r_pc[31:2];
        end
        S_RUN, S_MISS: begin
          r_ren <= 1'b1;
          if (iICACHE_stall) begin
            r_state <= S_MISS;
            if (iRedirect) begin
              r_pend_v  <= 1'b1;
              r_pend_pc <= iRedirectPC;
            end else begin
              r_pend_v  <= r_pend_v;
              r_pend_pc <= r_pend_pc;
            end
          end else begin
            r_state  <= S_RUN;
            r_pend_v <= 1'b0;
            r_pc     <= w_pc_next;
            r_addr   <= w_pc_next[31:2];
          end
        end
        default: begin
          r_state  <= S_BOOT;
          r_ren    <= 1'b0;
          r_pend_v <= 1'b0;
        end
      endcase
    end
  end

  assign oICACHE_ren  = r_ren;
  assign oICACHE_addr = r_addr;

  if_id_reg u_if_id (
    .clk        (clk),
    .rst        (rst),
    .i_hold     (w_hold),
    .i_flush    (w_flush),
    .i_load     (w_load),
    .i_ir       (iICACHE_rdata),
    .i_pc_plus4 (w_pc_plus4),
    .o_ir       (oIR),
    .o_pc_plus4 (oPC_plus4),
    .o_valid    (oValid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a combinational
// instruction-cache model whose stall line is driven by the bench.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        oICACHE_ren;
  logic [29:0] oICACHE_addr;
  logic [31:0] iICACHE_rdata;
  logic        iICACHE_stall;
  logic        iStall;
  logic        iRedirect;
  logic [31:0] iRedirectPC;
  logic [31:0] oIR;
  logic [31:0] oPC_plus4;
  logic        oValid;

  int errors;
  int checks;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .oICACHE_ren   (oICACHE_ren),
    .oICACHE_addr  (oICACHE_addr),
    .iICACHE_rdata (iICACHE_rdata),
    .iICACHE_stall (iICACHE_stall),
    .iStall        (iStall),
    .iRedirect     (iRedirect),
    .iRedirectPC   (iRedirectPC),
    .oIR           (oIR),
    .oPC_plus4     (oPC_plus4),
    .oValid        (oValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache contents: a short program at words 0..3, then 0x1000_0000 + word address.
  function automatic logic [31:0] cache_word(input logic [29:0] a);
    case (a)
      30'd0:   return 32'h2008_0005;
      30'd1:   return 32'h2009_000A;
      30'd2:   return 32'h0109_5020;
      30'd3:   return 32'hAC0A_0000;
      default: return 32'h1000_0000 + {2'b00, a};
    endcase
  endfunction

  always_comb iICACHE_rdata = cache_word(oICACHE_addr);

  task automatic test_reset();
    rst = 1'b1; iICACHE_stall = 1'b0; iStall = 1'b0; iRedirect = 1'b0; iRedirectPC = 32'h0;
    @(negedge clk); @(negedge clk);
    checks++; if (oICACHE_ren !== 1'b0) begin errors++; $display("FAIL rst_ren: got %b want 0", oICACHE_ren); end
    checks++; if (oICACHE_addr !== 30'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", oICACHE_addr); end
    checks++; if ({oValid, oIR, oPC_plus4} !== {1'b0, 32'h0, 32'h0}) begin errors++; $display("FAIL rst_ifid: got v=%b ir=%h pc4=%h want v=0 ir=0 pc4=0", oValid, oIR, oPC_plus4); end
    rst = 1'b0;
    #1;
    checks++; if (oICACHE_ren !== 1'b0) begin errors++; $display("FAIL boot_ren: got %b want 0", oICACHE_ren); end
    @(negedge clk);
    checks++; if ({oICACHE_ren, oICACHE_addr} !== {1'b1, 30'h0}) begin errors++; $display("FAIL req0: got ren=%b addr=%h want ren=1 addr=0", oICACHE_ren, oICACHE_addr); end
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL req0_valid: got %b want 0", oValid); end
    @(negedge clk);
    checks++; if ({oValid, oIR, oPC_plus4} !== {1'b1, 32'h2008_0005, 32'h4}) begin errors++; $display("FAIL first_insn: got v=%b ir=%h pc4=%h want v=1 ir=20080005 pc4=4", oValid, oIR, oPC_plus4); end
    checks++; if (oICACHE_addr !== 30'h1) begin errors++; $display("FAIL addr1: got %h want 1", oICACHE_addr); end
    @(negedge clk);
    checks++; if ({oIR, oPC_plus4} !== {32'h2009_000A, 32'h8}) begin errors++; $display("FAIL second_insn: got ir=%h pc4=%h want ir=2009000a pc4=8", oIR, oPC_plus4); end
    checks++; if (oICACHE_addr !== 30'h2) begin errors++; $display("FAIL addr2: got %h want 2", oICACHE_addr); end
  endtask

  task automatic test_stall();
    iStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) iStall = 1'b0;
      checks++; if (oICACHE_addr !== 30'h2) begin errors++; $display("FAIL stall_addr%0d: got %h want 2", i, oICACHE_addr); end
      checks++; if ({oValid, oIR} !== {1'b1, 32'h2009_000A}) begin errors++; $display("FAIL stall_ir%0d: got v=%b ir=%h want v=1 ir=2009000a", i, oValid, oIR); end
      @(negedge clk);
    end
    checks++; if ({oValid, oIR, oPC_plus4} !== {1'b1, 32'h0109_5020, 32'hC}) begin errors++; $display("FAIL after_stall: got v=%b ir=%h pc4=%h want v=1 ir=01095020 pc4=c", oValid, oIR, oPC_plus4); end
    @(negedge clk);
    checks++; if (oICACHE_addr !== 30'h4) begin errors++; $display("FAIL pc10_addr: got %h want 4", oICACHE_addr); end
  endtask

  task automatic test_redirect();
    iRedirect = 1'b1; iRedirectPC = 32'h0000_0040;
    @(negedge clk);
    iRedirect = 1'b0;
    checks++; if ({oValid, oIR} !== {1'b0, 32'h0}) begin errors++; $display("FAIL redir_bubble: got v=%b ir=%h want v=0 ir=0", oValid, oIR); end
    checks++; if (oICACHE_addr !== 30'h10) begin errors++; $display("FAIL redir_addr: got %h want 10", oICACHE_addr); end
    @(negedge clk);
    checks++; if ({oValid, oIR, oPC_plus4} !== {1'b1, 32'h1000_0010, 32'h44}) begin errors++; $display("FAIL redir_target: got v=%b ir=%h pc4=%h want v=1 ir=10000010 pc4=44", oValid, oIR, oPC_plus4); end
  endtask

  task automatic test_miss_redirect();
    iICACHE_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      iRedirect = (i == 1);
      iRedirectPC = (i == 1) ? 32'h0000_0100 : 32'h0000_0ABC;
      if (i > 0) begin
        checks++; if ({oICACHE_ren, oICACHE_addr} !== {1'b1, 30'h11}) begin errors++; $display("FAIL miss_addr%0d: got ren=%b addr=%h want ren=1 addr=11", i, oICACHE_ren, oICACHE_addr); end
        checks++; if ({oValid, oIR, oPC_plus4} !== {1'b1, 32'h1000_0010, 32'h44}) begin errors++; $display("FAIL miss_ifid%0d: got v=%b ir=%h pc4=%h want frozen", i, oValid, oIR, oPC_plus4); end
      end
      @(negedge clk);
    end
    iRedirect = 1'b0; iICACHE_stall = 1'b0;
    checks++; if (oICACHE_addr !== 30'h11) begin errors++; $display("FAIL miss_exit_addr: got %h want 11", oICACHE_addr); end
    @(negedge clk);
    checks++; if ({oValid, oIR} !== {1'b0, 32'h0}) begin errors++; $display("FAIL pend_bubble: got v=%b ir=%h want v=0 ir=0", oValid, oIR); end
    checks++; if (oICACHE_addr !== 30'h40) begin errors++; $display("FAIL pend_addr: got %h want 40", oICACHE_addr); end
    @(negedge clk);
    checks++; if ({oValid, oIR, oPC_plus4} !== {1'b1, 32'h1000_0040, 32'h104}) begin errors++; $display("FAIL pend_target: got v=%b ir=%h pc4=%h want v=1 ir=10000040 pc4=104", oValid, oIR, oPC_plus4); end
  endtask

  task automatic test_fresh_wins();
    iICACHE_stall = 1'b1; iStall = 1'b1;
    iRedirect = 1'b1; iRedirectPC = 32'h0000_0200;
    @(negedge clk);
    iRedirect = 1'b0;
    @(negedge clk);
    checks++; if (oICACHE_addr !== 30'h41) begin errors++; $display("FAIL both_stall_addr: got %h want 41", oICACHE_addr); end
    iICACHE_stall = 1'b0; iRedirect = 1'b1; iRedirectPC = 32'h0000_0300;
    @(negedge clk);
    iRedirect = 1'b0; iStall = 1'b0;
    checks++; if ({oValid, oICACHE_addr} !== {1'b0, 30'hC0}) begin errors++; $display("FAIL fresh_wins: got v=%b addr=%h want v=0 addr=c0", oValid, oICACHE_addr); end
    @(negedge clk);
    checks++; if ({oValid, oIR, oPC_plus4} !== {1'b1, 32'h1000_00C0, 32'h304}) begin errors++; $display("FAIL fresh_target: got v=%b ir=%h pc4=%h want v=1 ir=100000c0 pc4=304", oValid, oIR, oPC_plus4); end
  endtask

  task automatic test_wrap_and_align();
    iRedirect = 1'b1; iRedirectPC = 32'hFFFF_FFFC;
    @(negedge clk);
    iRedirect = 1'b0;
    checks++; if ({oValid, oICACHE_addr} !== {1'b0, 30'h3FFF_FFFF}) begin errors++; $display("FAIL wrap_addr: got v=%b addr=%h want v=0 addr=3fffffff", oValid, oICACHE_addr); end
    @(negedge clk);
    checks++; if ({oValid, oIR, oPC_plus4} !== {1'b1, 32'h4FFF_FFFF, 32'h0}) begin errors++; $display("FAIL wrap_ifid: got v=%b ir=%h pc4=%h want v=1 ir=4fffffff pc4=0", oValid, oIR, oPC_plus4); end
    checks++; if (oICACHE_addr !== 30'h0) begin errors++; $display("FAIL wrap_pc0: got %h want 0", oICACHE_addr); end
    iRedirect = 1'b1; iRedirectPC = 32'h0000_0043;
    @(negedge clk);
    iRedirect = 1'b0;
    checks++; if (oICACHE_addr !== 30'h10) begin errors++; $display("FAIL align_addr: got %h want 10", oICACHE_addr); end
    @(negedge clk);
    checks++; if ({oIR, oPC_plus4} !== {32'h1000_0010, 32'h44}) begin errors++; $display("FAIL align_ifid: got ir=%h pc4=%h want ir=10000010 pc4=44", oIR, oPC_plus4); end
  endtask

  task automatic test_reset_mid_miss();
    iICACHE_stall = 1'b1;
    iRedirect = 1'b1; iRedirectPC = 32'h0000_0080;
    @(negedge clk);
    iRedirect = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if ({oICACHE_ren, oICACHE_addr} !== {1'b0, 30'h0}) begin errors++; $display("FAIL midrst_req: got ren=%b addr=%h want ren=0 addr=0", oICACHE_ren, oICACHE_addr); end
    checks++; if ({oValid, oIR, oPC_plus4} !== {1'b0, 32'h0, 32'h0}) begin errors++; $display("FAIL midrst_ifid: got v=%b ir=%h pc4=%h want all 0", oValid, oIR, oPC_plus4); end
    iICACHE_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (oICACHE_ren !== 1'b0) begin errors++; $display("FAIL midrst_boot: got ren=%b want 0", oICACHE_ren); end
    @(negedge clk);
    checks++; if ({oICACHE_ren, oICACHE_addr} !== {1'b1, 30'h0}) begin errors++; $display("FAIL midrst_req0: got ren=%b addr=%h want ren=1 addr=0", oICACHE_ren, oICACHE_addr); end
    @(negedge clk);
    checks++; if ({oValid, oIR, oPC_plus4} !== {1'b1, 32'h2008_0005, 32'h4}) begin errors++; $display("FAIL midrst_nopend: got v=%b ir=%h pc4=%h want v=1 ir=20080005 pc4=4", oValid, oIR, oPC_plus4); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_stall();
    test_redirect();
    test_miss_redirect();
    test_fresh_wins();
    test_wrap_and_align();
    test_reset_mid_miss();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
